// File: rtl/control_puertas.sv
// Door sequencer and floor-request register for the 4-floor elevator; state and s update one cycle after inputs.
// Holds the motion algorithm via esperar while the door is not closed. Optional macro BOTON_ABRIR_EN adds the abrir door-open button.
module control_puertas #(
    parameter int T_PUERTA  = 4,
    parameter int T_ABIERTA = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] botones,
    input  logic [3:0] estado,
`ifdef BOTON_ABRIR_EN
    input  logic       abrir,
`endif
    output logic [9:0] s,
    output logic       esperar,
    output logic       puerta_abierta
);

    localparam int T_MAX = (T_PUERTA > T_ABIERTA) ? T_PUERTA : T_ABIERTA;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] T_P   = TW'(T_PUERTA);
    localparam logic [TW-1:0] T_A   = TW'(T_ABIERTA);
    localparam logic [TW-1:0] T_UNO = TW'(1);

    typedef enum logic [1:0] {CERRADA, ABRIENDO, ABIERTA, CERRANDO} puerta_t;

    puerta_t       est, est_sig;
    logic [TW-1:0] tim, tim_sig;
    logic [9:0]    req;
    logic [9:0]    servir;
    logic [3:0]    piso_req;
    logic [1:0]    piso;
    logic          subiendo;
    logic          mas_alla;
    logic          hit;
    logic          abrir_ok;

    assign req      = s | botones;
    assign piso     = estado[1:0];
    assign subiendo = estado[2];

    assign piso_req[0] = req[0] | req[6];
    assign piso_req[1] = req[1] | req[2] | req[7];
    assign piso_req[2] = req[3] | req[4] | req[8];
    assign piso_req[3] = req[5] | req[9];

    // Any pending request on a floor further along the current direction.
    always_comb begin
        mas_alla = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (subiendo ? (i > int'(piso)) : (i < int'(piso)))
                mas_alla = mas_alla | piso_req[i];
        end
    end

    always_comb begin
        servir = '0;
        if (!estado[3]) begin
            servir[6 + int'(piso)] = 1'b1;
            case (piso)
                2'd0: servir[0] = 1'b1;
                2'd1: begin
                    if (subiendo) servir[2] = 1'b1;
                    else          servir[1] = 1'b1;
                    if (!mas_alla) begin
                        if (subiendo) servir[1] = 1'b1;
                        else          servir[2] = 1'b1;
                    end
                end
                2'd2: begin
                    if (subiendo) servir[4] = 1'b1;
                    else          servir[3] = 1'b1;
                    if (!mas_alla) begin
                        if (subiendo) servir[3] = 1'b1;
                        else          servir[4] = 1'b1;
                    end
                end
                default: servir[5] = 1'b1;
            endcase
        end
    end

    assign hit = |(botones & servir);

`ifdef BOTON_ABRIR_EN
    assign abrir_ok = abrir & ~estado[3];
`else
    assign abrir_ok = 1'b0;
`endif

    always_comb begin
        est_sig = est;
        tim_sig = tim;
        case (est)
            CERRADA: begin
                if (!estado[3] && ((|(servir & req)) || abrir_ok)) begin
                    est_sig = ABRIENDO;
                    tim_sig = T_P;
                end
            end
            ABRIENDO: begin
                if (tim == T_UNO) begin
                    est_sig = ABIERTA;
                    tim_sig = T_A;
                end else begin
                    tim_sig = tim - T_UNO;
                end
            end
            ABIERTA: begin
                if (hit || abrir_ok) begin
                    tim_sig = T_A;
                end else if (tim == T_UNO) begin
                    est_sig = CERRANDO;
                    tim_sig = T_P;
                end else begin
                    tim_sig = tim - T_UNO;
                end
            end
            default: begin
                if (hit || abrir_ok) begin
                    est_sig = ABRIENDO;
                    tim_sig = T_P;
                end else if (tim == T_UNO) begin
                    est_sig = CERRADA;
                    tim_sig = '0;
                end else begin
                    tim_sig = tim - T_UNO;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            est <= CERRADA;
            tim <= '0;
            s   <= '0;
        end else begin
            est <= est_sig;
            tim <= tim_sig;
            s   <= (s | botones) & ~servir;
        end
    end

    assign esperar        = (est != CERRADA);
    assign puerta_abierta = (est == ABIERTA);

endmodule

// File: tb/tb_control_puertas.sv
// Directed bench for control_puertas: expected values queued at drive time, compared after the edge.
module tb_control_puertas;

    logic       clk;
    logic       reset;
    logic [9:0] botones;
    logic [3:0] estado;
    logic [9:0] s;
    logic       esperar;
    logic       puerta_abierta;
`ifdef BOTON_ABRIR_EN
    logic       abrir;
`endif

    int    n_cmp;
    int    n_err;
    string tq[$];
    logic [31:0] vq[$];

    control_puertas #(.T_PUERTA(4), .T_ABIERTA(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .botones        (botones),
        .estado         (estado),
`ifdef BOTON_ABRIR_EN
        .abrir          (abrir),
`endif
        .s              (s),
        .esperar        (esperar),
        .puerta_abierta (puerta_abierta)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input string t, input logic [31:0] v);
        tq.push_back(t);
        vq.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        t = tq.pop_front();
        v = vq.pop_front();
        n_cmp++;
        assert (obs === v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", t, obs, v);
        end
    endtask

    task automatic cyc(input logic [9:0] b, input logic [3:0] e);
        @(negedge clk);
        botones = b;
        estado  = e;
        @(posedge clk);
        #1;
    endtask

    // Expected word packs {s, esperar, puerta_abierta}.
    task automatic step(input logic [9:0] b, input logic [3:0] e, input logic [9:0] es,
                        input logic ee, input logic ep, input string t);
        @(negedge clk);
        botones = b;
        estado  = e;
        push(t, {20'b0, es, ee, ep});
        @(posedge clk);
        #1;
        pop_cmp({20'b0, s, esperar, puerta_abierta});
    endtask

    // Counts the remaining door-busy and door-open cycles until the door closes.
    task automatic run_door(input logic [3:0] e, input string t, input int exp_esp, input int exp_pa);
        int n_esp;
        int n_pa;
        n_esp = 0;
        n_pa  = 0;
        push({t, "_esperar"}, exp_esp);
        push({t, "_abierta"}, exp_pa);
        for (int i = 0; i < 200; i++) begin
            cyc(10'h000, e);
            if (!esperar) break;
            n_esp++;
            if (puerta_abierta) n_pa++;
        end
        pop_cmp(n_esp);
        pop_cmp(n_pa);
    endtask

    initial begin
        int n_pa;
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        botones = 10'h3FF;
        estado  = 4'b0000;
`ifdef BOTON_ABRIR_EN
        abrir   = 1'b0;
`endif

        step(10'h3FF, 4'b0000, 10'h000, 1'b0, 1'b0, "reset_1");
        step(10'h3FF, 4'b0000, 10'h000, 1'b0, 1'b0, "reset_2");
        reset = 1'b0;
        step(10'h000, 4'b1110, 10'h000, 1'b0, 1'b0, "post_reset");

        // Moving: requests latch, door never moves.
        step(10'h100, 4'b1110, 10'h100, 1'b0, 1'b0, "latch_cabin_f3");
        cyc(10'h000, 4'b1110);
        cyc(10'h000, 4'b1110);
        step(10'h000, 4'b1110, 10'h100, 1'b0, 1'b0, "latch_holds");
        step(10'h010, 4'b1110, 10'h110, 1'b0, 1'b0, "latch_hall_f3_up");

        // Stop at floor 2 going up: both served in one cycle, full door cycle.
        step(10'h000, 4'b0110, 10'h000, 1'b1, 1'b0, "serve_f3");
        run_door(4'b0110, "cycle_f3", 23, 16);

        // Floor 1 going up, only the down hall request: no requests above, so it is served.
        step(10'h002, 4'b1101, 10'h002, 1'b0, 1'b0, "latch_f2_down");
        step(10'h000, 4'b0101, 10'h000, 1'b1, 1'b0, "serve_opposite");
        run_door(4'b0101, "cycle_f2", 23, 16);

        // Same with a request above: the opposite-direction bit is kept.
        step(10'h022, 4'b1101, 10'h022, 1'b0, 1'b0, "latch_f2d_f4d");
        step(10'h000, 4'b0101, 10'h022, 1'b0, 1'b0, "keep_opposite");
        step(10'h000, 4'b0101, 10'h022, 1'b0, 1'b0, "keep_opposite_2");
        step(10'h000, 4'b0011, 10'h002, 1'b1, 1'b0, "serve_f4");
        run_door(4'b0011, "cycle_f4", 23, 16);
        step(10'h000, 4'b0001, 10'h000, 1'b1, 1'b0, "serve_f2_down");
        run_door(4'b0001, "cycle_f2_down", 23, 16);

        // Floor 0: press and serve together, then extend the open phase at timer=3.
        step(10'h040, 4'b0000, 10'h000, 1'b1, 1'b0, "press_and_serve");
        for (int i = 0; i < 17; i++) cyc(10'h000, 4'b0000);
        step(10'h001, 4'b0000, 10'h000, 1'b1, 1'b1, "extend_press");
        n_pa = 1;
        for (int i = 0; i < 100; i++) begin
            cyc(10'h000, 4'b0000);
            if (!puerta_abierta) break;
            n_pa++;
        end
        push("extend_len", 32'd16);
        pop_cmp(n_pa);
        push("closing_after_extend", 32'd1);
        pop_cmp({31'b0, esperar});
        step(10'h001, 4'b0000, 10'h000, 1'b1, 1'b0, "closing_reopen");
        cyc(10'h000, 4'b0000);
        cyc(10'h000, 4'b0000);
        step(10'h000, 4'b0000, 10'h000, 1'b1, 1'b0, "reopening");
        step(10'h000, 4'b0000, 10'h000, 1'b1, 1'b1, "reopened");
        run_door(4'b0000, "cycle_reopen", 19, 15);

`ifdef BOTON_ABRIR_EN
        step(10'h200, 4'b1000, 10'h200, 1'b0, 1'b0, "latch_f4_cabin");
        @(negedge clk);
        abrir = 1'b1;
        step(10'h000, 4'b0000, 10'h200, 1'b1, 1'b0, "abrir_start");
        abrir = 1'b0;
        run_door(4'b0000, "cycle_abrir", 23, 16);
        step(10'h000, 4'b0000, 10'h200, 1'b0, 1'b0, "abrir_s_kept");
        @(negedge clk);
        abrir = 1'b1;
        step(10'h000, 4'b1000, 10'h200, 1'b0, 1'b0, "abrir_moving");
        abrir = 1'b0;
        step(10'h000, 4'b1000, 10'h200, 1'b0, 1'b0, "abrir_moving_2");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_puertas.md
Name: control_puertas

Overview:
- Sequences the cabin door and owns the floor-request register for the 4-floor elevator.
- Latches hall and cabin button pulses into the 10-bit request vector consumed by the motion algorithm.
- When the cabin is stopped at a floor with a serviceable request, it clears the served bits and runs the open/hold/close door cycle.
- Holds the motion algorithm with esperar while the door is not fully closed.

Parameters:
T_PUERTA, 4, cycles the door spends in ABRIENDO and in CERRANDO (>=1)
T_ABIERTA, 16, cycles the door is held fully open (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
botones  input  10  one-cycle button pulses; bit map identical to s
estado  input  4  elevator state: [3]=moving, [2]=up(1)/down(0), [1:0]=floor 0..3
s  output  10  latched requests: [0]=F1 up, [1]=F2 down, [2]=F2 up, [3]=F3 down, [4]=F3 up, [5]=F4 down, [9:6]=cabin F1..F4
esperar  output  1  high whenever the door state is not CERRADA
puerta_abierta  output  1  high only in ABIERTA

Behaviour:
- Reset: s=0, door state=CERRADA, timer=0, esperar=0, puerta_abierta=0. Reset has priority over everything, including mid-cycle door operation.
- Request latch:
  - s <= (s | botones) & ~servir, where servir is the serve mask computed in the same cycle.
  - A press is visible on s one cycle after its pulse.
- Serve mask:
  - The mask is 0 when estado[3]=1.
  - Otherwise, for floor f, the mask contains the cabin bit 6+f.
  - It also contains the hall bit matching direction estado[2]. F1 always uses bit0 and F4 always uses bit5.
  - It contains the opposite hall bit of floor f only when no request (s|botones) exists for any floor beyond f in the current direction.
- Door FSM (states CERRADA, ABRIENDO, ABIERTA, CERRANDO; timer counts down to 1):
  - CERRADA -> ABRIENDO when estado[3]=0 and (servir & (s|botones)) != 0. The bits are cleared that same cycle and the timer loads T_PUERTA.
  - ABRIENDO -> ABIERTA when the timer reaches 1. The timer then loads T_ABIERTA.
  - ABIERTA -> CERRANDO when the timer reaches 1. The timer then loads T_PUERTA.
  - If a press in ABIERTA hits a bit in servir, the bit is not latched and the timer reloads T_ABIERTA.
  - CERRANDO -> ABRIENDO, with the timer loading T_PUERTA, when a press hits the serve mask. The bit is not latched.
  - CERRANDO -> CERRADA when the timer reaches 1.
- While esperar=1, the serve mask is evaluated from estado as held. estado is frozen by the algorithm while esperar is high.
- If estado[3]=1 while the door is not CERRADA, that is a protocol violation. The FSM continues its sequence and servir is forced to 0.
- Simultaneous press and serve of the same bit: serve wins (the bit stays 0).
- Timer width is clog2(max(T_PUERTA,T_ABIERTA)+1). No wrap is possible because the timer never decrements below 1.

Optional Feature:
- Macro BOTON_ABRIR_EN.
- When defined:
  - Adds input abrir (1 bit, pulse).
  - In ABIERTA, a pulse reloads T_ABIERTA.
  - In CERRANDO, a pulse returns the FSM to ABRIENDO with T_PUERTA.
  - In CERRADA with estado[3]=0, a pulse starts ABRIENDO with no bits cleared.
  - While the cabin is moving, the pulse is ignored.
- When not defined: there is no abrir port, and the door opens only on a serviceable request.

Test Plan:
- Reset for 2 cycles with botones=10'h3FF -> s=0, esperar=0 during reset and on the first cycle after it.
- estado=4'b1110 (moving up, floor 2), botones[8] pulse -> s=10'h100 the next cycle and stays set. No door activity.
- estado=4'b0110 (stopped, up, floor 2) with s[8]=1 and s[4]=1 -> both clear in 1 cycle. esperar high for 4+16+4=24 cycles. puerta_abierta high for exactly 16 of them.
- estado=4'b0101 (stopped, up, floor 1) with only s[1] set -> s[1] clears (no requests above) and the door cycles. With s[1]=1 and s[5]=1, s[1] is kept.
- In ABIERTA at floor 0, pulse botones[0] at timer=3 -> s[0] stays 0 and the open phase extends to 16 cycles from the pulse. In CERRANDO, the same pulse returns the FSM to ABRIENDO.
- With BOTON_ABRIR_EN: at estado=4'b0000 and s=0, an abrir pulse -> full 24-cycle door cycle with s unchanged. The same pulse with estado[3]=1 -> no effect.
